// File: rtl/net_packet_buffer_pkg.sv
// Shared types and constants for the store-and-forward packet buffer.
package net_pkt_pkg;

  localparam int unsigned NET_DATA_WIDTH = 64;

  typedef struct packed {
    logic [NET_DATA_WIDTH-1:0] data;
    logic                      last;
  } net_flit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } net_rx_state_e;

endpackage

// File: rtl/net_packet_buffer_if.sv
// Flit stream bundle: network-side input channel plus NIC-side output channel.
// slave is the buffer's view, master is the environment's view.
interface net_packet_buffer_if #(
  parameter int unsigned DATA_WIDTH = net_pkt_pkg::NET_DATA_WIDTH
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_bits_data;
  logic                  in_bits_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_bits_data;
  logic                  out_bits_last;

  modport master (
    output in_valid, in_bits_data, in_bits_last, out_ready,
    input  in_ready, out_valid, out_bits_data, out_bits_last
  );

  modport slave (
    input  in_valid, in_bits_data, in_bits_last, out_ready,
    output in_ready, out_valid, out_bits_data, out_bits_last
  );

endinterface

// File: rtl/net_packet_buffer_len_fifo.sv
// Synchronous FIFO of committed packet lengths. Push and pop in the same
// cycle are both honoured even when full; a pop while empty is ignored.
module net_len_fifo
  import net_pkt_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 7
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, rd_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, empty, do_push, do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  // Occupancy flags and the pointer/count next-state.
  always_comb begin
    full    = (count_q == CW'(DEPTH));
    empty   = (count_q == '0);
    do_pop  = pop_i && !empty;
    do_push = push_i && (!full || do_pop);
    rd_d    = do_pop  ? ptr_next(rd_q) : rd_q;
    wr_d    = do_push ? ptr_next(wr_q) : wr_q;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Pointer and count registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Length storage; contents are meaningful only while counted.
  always_ff @(posedge clock) begin
    if (do_push && !reset) mem_q[wr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;

endmodule

// File: rtl/net_packet_buffer.sv
// Store-and-forward receive buffer. Flits are written speculatively and only
// become visible to the output once the final flit commits the packet.
// Packets that cannot fit are dropped whole; the input is never stalled.
module net_packet_buffer
  import net_pkt_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = NET_DATA_WIDTH,
  parameter int unsigned BUF_WORDS  = 64,
  parameter int unsigned MAX_PKTS   = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  net_packet_buffer_if.slave          bus,
  output logic [CNT_WIDTH-1:0]        drop_count,
  output logic [$clog2(MAX_PKTS):0]   pkt_count
);

  localparam int unsigned AW  = $clog2(BUF_WORDS);
  localparam int unsigned UW  = AW + 1;
  localparam int unsigned PCW = $clog2(MAX_PKTS) + 1;

  logic [DATA_WIDTH-1:0] ram_q [BUF_WORDS];

  logic [AW-1:0]         head_q, head_d;
  logic [AW-1:0]         tail_q, tail_d;
  logic [AW-1:0]         wr_q, wr_d;
  logic [UW-1:0]         used_q, used_d;
  logic [UW-1:0]         spec_q, spec_d;
  logic [UW-1:0]         rd_idx_q, rd_idx_d;
  logic [CNT_WIDTH-1:0]  drop_q, drop_d;
  net_rx_state_e         state_q, state_d;

  logic                  ram_we;
  logic                  push, pop;
  logic [UW-1:0]         spec_inc;
  logic [UW-1:0]         len_head;
  logic [PCW-1:0]        pkt_cnt;
  logic                  has_space, room_pkt;
  logic                  out_valid, out_last, out_fire;
  logic [UW-1:0]         commit_amt, pop_amt;

  net_len_fifo #(
    .DEPTH (MAX_PKTS),
    .WIDTH (UW)
  ) u_len_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (spec_inc),
    .pop_i       (pop),
    .head_o      (len_head),
    .count_o     (pkt_cnt)
  );

  // Admission: space and packet-slot checks use registered occupancy, so
  // anything freed by the output this cycle only counts from the next one.
  always_comb begin
    spec_inc   = spec_q + 1'b1;
    has_space  = (spec_q < (UW'(BUF_WORDS) - used_q));
    room_pkt   = (pkt_cnt < PCW'(MAX_PKTS));
    state_d    = state_q;
    wr_d       = wr_q;
    tail_d     = tail_q;
    spec_d     = spec_q;
    drop_d     = drop_q;
    ram_we     = 1'b0;
    push       = 1'b0;
    commit_amt = '0;
    if (bus.in_valid) begin
      case (state_q)
        IDLE, RECV: begin
          if (has_space && (!bus.in_bits_last || room_pkt)) begin
            ram_we = 1'b1;
            wr_d   = wr_q + 1'b1;
            if (bus.in_bits_last) begin
              push       = 1'b1;
              commit_amt = spec_inc;
              tail_d     = wr_q + 1'b1;
              spec_d     = '0;
              state_d    = IDLE;
            end else begin
              spec_d  = spec_inc;
              state_d = RECV;
            end
          end else begin
            wr_d    = tail_q;
            spec_d  = '0;
            drop_d  = (drop_q == '1) ? drop_q : drop_q + 1'b1;
            state_d = bus.in_bits_last ? IDLE : DROP;
          end
        end
        DROP: begin
          if (bus.in_bits_last) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Delivery: walk the head packet flit by flit, popping its length on last.
  always_comb begin
    out_valid = (pkt_cnt != '0);
    out_last  = out_valid && (rd_idx_q == len_head - 1'b1);
    out_fire  = out_valid && bus.out_ready;
    pop       = out_fire && out_last;
    head_d    = out_fire ? head_q + 1'b1 : head_q;
    if (pop)           rd_idx_d = '0;
    else if (out_fire) rd_idx_d = rd_idx_q + 1'b1;
    else               rd_idx_d = rd_idx_q;
    pop_amt   = {{(UW-1){1'b0}}, out_fire};
    used_d    = used_q + commit_amt - pop_amt;
  end

  // State, pointer and counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      head_q   <= '0;
      tail_q   <= '0;
      wr_q     <= '0;
      used_q   <= '0;
      spec_q   <= '0;
      rd_idx_q <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      wr_q     <= wr_d;
      used_q   <= used_d;
      spec_q   <= spec_d;
      rd_idx_q <= rd_idx_d;
      drop_q   <= drop_d;
    end
  end

  // Flit storage, written at the speculative pointer.
  always_ff @(posedge clock) begin
    if (ram_we && !reset) ram_q[wr_q] <= bus.in_bits_data;
  end

  assign bus.in_ready      = 1'b1;
  assign bus.out_valid     = out_valid;
  assign bus.out_bits_data = ram_q[head_q];
  assign bus.out_bits_last = out_last;
  assign drop_count        = drop_q;
  assign pkt_count         = pkt_cnt;

endmodule
